// File: rtl/fpu_to_int.sv
// Iterative float-to-integer converter for the FPU word format.
// Round to nearest, ties away from zero; one shift step per clock.
module fpu_to_int #(
  parameter int BIAS    = 31,
  parameter int MAX_RSH = 27
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] float_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] int_out,
  output logic [3:0]  status_out
);

  localparam logic [3:0] ST_EXACT = 4'b0001;
  localparam logic [3:0] ST_INEX  = 4'b0010;
  localparam logic [3:0] ST_OVF   = 4'b0100;
  localparam logic [3:0] ST_UNF   = 4'b1000;

  localparam logic        [7:0] BIAS8 = 8'(BIAS);
  localparam logic signed [7:0] RCAP  = 8'(MAX_RSH);

  typedef enum logic [1:0] {
    IDLE,
    UNPACK,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0] fin;
  logic [31:0] acc;
  logic        guard;
  logic        sticky;
  logic [4:0]  cnt;
  logic        left;
  logic [31:0] res;
  logic [3:0]  stat;

  // field decode of the captured operand
  logic        sgn;
  logic [5:0]  ex;
  logic [24:0] mant;
  logic [25:0] sig;
  logic signed [7:0] e;
  logic signed [7:0] k;
  logic signed [7:0] nk;

  assign sgn  = fin[31];
  assign ex   = fin[30:25];
  assign mant = fin[24:0];
  assign sig  = {(ex != 6'd0), mant};
  assign e    = {2'b00, ex} - BIAS8;
  assign k    = e - 8'sd25;
  assign nk   = -k;

  logic zero;
  logic den;
  logic ovf;
  logic big;
  logic early;
  logic [3:0] estat;
  logic [4:0] cnt_init;

  assign zero = (ex == 6'd0) && (mant == '0);
  assign den  = (ex == 6'd0) && (mant != '0);
  assign ovf  = (e >= 8'sd31) &&
                !(sgn && (e == 8'sd31) && (mant == '0));
  assign big  = k[7] && (nk > RCAP);

  always_comb begin
    early = 1'b1;
    estat = ST_EXACT;
    unique case (1'b1)
      zero:    estat = ST_EXACT;
      den:     estat = ST_UNF;
      ovf:     estat = ST_OVF;
      default: early = 1'b0;
    endcase
  end

  always_comb begin
    cnt_init = k[4:0];
    if (k[7]) begin
      cnt_init = big ? RCAP[4:0] : nk[4:0];
    end
  end

  // one shift step plus the rounding of its result
  logic [31:0] sh_acc;
  logic        sh_g;
  logic        sh_s;
  logic [31:0] mag;
  logic [31:0] sint;
  logic [3:0]  rstat;
  logic        last;

  always_comb begin
    sh_acc = acc;
    sh_g   = guard;
    sh_s   = sticky;
    if (cnt != 5'd0) begin
      if (left) begin
        sh_acc = acc << 1;
      end else begin
        sh_acc = acc >> 1;
        sh_g   = acc[0];
        sh_s   = sticky | guard;
      end
    end
    mag  = sh_acc + {31'd0, sh_g};
    sint = sgn ? -mag : mag;
    if (mag == 32'd0) begin
      rstat = ST_UNF;
    end else if (sh_g | sh_s) begin
      rstat = ST_INEX;
    end else begin
      rstat = ST_EXACT;
    end
  end

  // rounding is folded into the final shift cycle
  assign last = (cnt <= 5'd1);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = UNPACK;
      UNPACK:  state_nx = early ? DONE : SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      fin    <= '0;
      acc    <= '0;
      guard  <= 1'b0;
      sticky <= 1'b0;
      cnt    <= '0;
      left   <= 1'b0;
      res    <= '0;
      stat   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) fin <= float_in;
        end
        UNPACK: begin
          acc    <= big ? 32'd0 : {6'd0, sig};
          guard  <= 1'b0;
          sticky <= big & (|sig);
          cnt    <= cnt_init;
          left   <= !k[7];
          if (early) begin
            res  <= '0;
            stat <= estat;
          end
        end
        SHIFT: begin
          acc    <= sh_acc;
          guard  <= sh_g;
          sticky <= sh_s;
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
          if (last) begin
            res  <= sint;
            stat <= rstat;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign int_out    = res;
  assign status_out = stat;

endmodule
